// File: rtl/mcu51_pkg.sv
// Shared 8051 core definitions used by the multi-cycle MUL/DIV unit.
package mcu51_pkg;

   localparam int WORD_W = 8;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MUL AB / DIV AB unit: one bit per clock, start/done handshake.
import mcu51_pkg::*;

module muldiv_unit #(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a_data,
   input  logic [WIDTH-1:0] b_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             ov_out,
   output logic             c_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   muldiv_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic ov_q, ov_d, c_q, c_d;

   logic [WIDTH:0] mul_sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;
   logic ge;
   logic [2*WIDTH-1:0] mul_acc, div_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         acc_q <= '0;
         opnd_q <= '0;
         op_q <= OP_MUL;
         a_q <= '0;
         b_q <= '0;
         ov_q <= 1'b0;
         c_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         opnd_q <= opnd_d;
         op_q <= op_d;
         a_q <= a_d;
         b_q <= b_d;
         ov_q <= ov_d;
         c_q <= c_d;
      end
   end

   // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
      ge = (rem_sh >= {1'b0, opnd_q});
      diff = rem_sh - {1'b0, opnd_q};
      div_acc = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      opnd_d = opnd_q;
      op_d = op_q;
      a_d = a_q;
      b_d = b_q;
      ov_d = ov_q;
      c_d = c_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d = op;
               cnt_d = '0;
               if (op == OP_DIV && b_data == '0) begin
                  state_d = DONE;
                  a_d = '1;
                  b_d = a_data;
                  ov_d = 1'b1;
                  c_d = 1'b0;
               end else begin
                  state_d = CALC;
                  opnd_d = (op == OP_DIV) ? b_data : a_data;
                  acc_d = {{WIDTH{1'b0}},
                           (op == OP_DIV) ? a_data : b_data};
               end
            end
         end
         CALC: begin
            acc_d = (op_q == OP_MUL) ? mul_acc : div_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               a_d = acc_d[WIDTH-1:0];
               b_d = acc_d[2*WIDTH-1:WIDTH];
               ov_d = (op_q == OP_MUL) && (|acc_d[2*WIDTH-1:WIDTH]);
               c_d = 1'b0;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign a_out = a_q;
   assign b_out = b_q;
   assign ov_out = ov_q;
   assign c_out = c_q;

endmodule
